trigger_arbiter: RTL and testbench

Trigger arbiter and sequencer for the SDE trigger block, running at 120 MHz. It collects one-cycle trigger pulses from the per-source trigger modules (single bin 40/120 MHz, ToT, ToTd, MoPS, external) and applies a per-source mask and prescaler. Qualified pulses that fall inside a short coincidence window are merged into a single event request, with a type mask, that is handed to the event buffer writer over a REQ/ACK handshake. Programmable dead time, buffer-full blocking, and event and lost-trigger counters complete the block.

---
 rtl/trigger_arbiter_pkg.sv | 37 +++
 rtl/trigger_arbiter_if.sv | 32 +++
 rtl/trig_prescaler.sv | 55 +++++
 rtl/trigger_arbiter.sv | 149 ++++++++++++++
 tb/tb_trigger_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_arbiter_pkg.sv
// Shared definitions for the SDE trigger arbiter: default sizes, trigger
// source indices, sequencer state encoding and a saturating counter helper.
package trigger_arbiter_pkg;

    localparam int NSRC_DEF       = 6;
    localparam int PS_WIDTH_DEF   = 8;
    localparam int DEAD_WIDTH_DEF = 16;
    localparam int COINC_WIN_DEF  = 3;
    localparam int CNT_WIDTH      = 16;

    // Bit position of each trigger source in TRIG_IN / TRIG_MASK / EVT_TYPE
    localparam int TRG_SRC_SB40  = 0;
    localparam int TRG_SRC_SB120 = 1;
    localparam int TRG_SRC_TOT   = 2;
    localparam int TRG_SRC_TOTD  = 3;
    localparam int TRG_SRC_MOPS  = 4;
    localparam int TRG_SRC_EXT   = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_REQ    = 2'd2,
        ST_DEAD   = 2'd3
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/trigger_arbiter_if.sv
// Bundle of the trigger inputs, configuration and event-request handshake
// between the trigger arbiter (slave) and its surroundings (master).
interface trigger_arbiter_if #(
    parameter int NSRC       = 6,
    parameter int PS_WIDTH   = 8,
    parameter int DEAD_WIDTH = 16
);
    import trigger_arbiter_pkg::*;

    logic [NSRC-1:0]          TRIG_IN;
    logic [NSRC-1:0]          TRIG_MASK;
    logic [NSRC*PS_WIDTH-1:0] PRESCALE;
    logic [DEAD_WIDTH-1:0]    DEAD_TIME;
    logic                     BUF_FULL;
    logic                     EVT_ACK;
    logic                     EVT_REQ;
    logic [NSRC-1:0]          EVT_TYPE;
    logic                     BUSY;
    logic [CNT_WIDTH-1:0]     EVT_CNT;
    logic [CNT_WIDTH-1:0]     LOST_CNT;

    modport master (
        output TRIG_IN, TRIG_MASK, PRESCALE, DEAD_TIME, BUF_FULL, EVT_ACK,
        input  EVT_REQ, EVT_TYPE, BUSY, EVT_CNT, LOST_CNT
    );

    modport slave (
        input  TRIG_IN, TRIG_MASK, PRESCALE, DEAD_TIME, BUF_FULL, EVT_ACK,
        output EVT_REQ, EVT_TYPE, BUSY, EVT_CNT, LOST_CNT
    );

endinterface

// File: rtl/trig_prescaler.sv
// Per-source prescaler: passes one of every N input pulses (N of 0 or 1
// passes all). The terminal test is "count >= N-1" so that lowering N while
// a count is in progress releases the very next pulse.
module trig_prescaler #(
    parameter int PS_WIDTH = 8
) (
    input  logic                CLK120,
    input  logic                RST_N,
    input  logic                IN,
    input  logic [PS_WIDTH-1:0] PRESCALE,
    output logic                OUT
);

    localparam logic [PS_WIDTH-1:0] PS_ONE = PS_WIDTH'(1);

    logic [PS_WIDTH-1:0] cnt_q;
    logic [PS_WIDTH-1:0] cnt_d;
    logic                out_q;
    logic                out_d;

    // Next count and pass decision for the current masked pulse
    always_comb begin
        cnt_d = cnt_q;
        out_d = 1'b0;
        if (IN) begin
            if (PRESCALE <= PS_ONE) begin
                cnt_d = '0;
                out_d = 1'b1;
            end else if (cnt_q >= (PRESCALE - PS_ONE)) begin
                cnt_d = '0;
                out_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PS_ONE;
                out_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
            out_d = 1'b0;
        end
    end

    // Count and registered qualified pulse
    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: rtl/trigger_arbiter.sv
// Trigger arbiter and sequencer: registers and masks trigger pulses,
// prescales them per source, merges qualified pulses falling into a short
// coincidence window into one typed event request, then enforces dead time.
// Pulses that cannot become an event are counted in a saturating counter.
module trigger_arbiter
    import trigger_arbiter_pkg::*;
#(
    parameter int NSRC       = NSRC_DEF,
    parameter int PS_WIDTH   = PS_WIDTH_DEF,
    parameter int DEAD_WIDTH = DEAD_WIDTH_DEF,
    parameter int COINC_WIN  = COINC_WIN_DEF
) (
    input  logic             CLK120,
    input  logic             RST_N,
    trigger_arbiter_if.slave bus
);

    localparam int                    WIN_W    = (COINC_WIN > 1) ? $clog2(COINC_WIN) : 1;
    localparam logic [WIN_W-1:0]      WIN_LOAD = WIN_W'(COINC_WIN - 1);
    localparam logic [WIN_W-1:0]      WIN_ONE  = WIN_W'(1);
    localparam logic [DEAD_WIDTH-1:0] DEAD_ONE = DEAD_WIDTH'(1);

    logic [NSRC-1:0]       trig_q;
    logic [NSRC-1:0]       masked_s;
    logic [NSRC-1:0]       qual_s;
    logic                  any_qual_s;
    logic                  lost_hit_s;

    arb_state_e            state_q;
    logic [WIN_W-1:0]      win_q;
    logic [DEAD_WIDTH-1:0] dead_q;
    logic                  evt_req_q;
    logic [NSRC-1:0]       evt_type_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  evt_cnt_q;
    logic [CNT_WIDTH-1:0]  lost_cnt_q;

    // Input register for the raw one-cycle trigger pulses
    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            trig_q <= '0;
        end else begin
            trig_q <= bus.TRIG_IN;
        end
    end

    assign masked_s = trig_q & bus.TRIG_MASK;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ps
        trig_prescaler #(
            .PS_WIDTH (PS_WIDTH)
        ) u_ps (
            .CLK120   (CLK120),
            .RST_N    (RST_N),
            .IN       (masked_s[gi]),
            .PRESCALE (bus.PRESCALE[gi*PS_WIDTH +: PS_WIDTH]),
            .OUT      (qual_s[gi])
        );
    end

    assign any_qual_s = |qual_s;

    // A qualified pulse is lost when the buffer blocks a new event or when
    // an event is already pending / in dead time; one count per cycle
    always_comb begin
        lost_hit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_qual_s && bus.BUF_FULL) begin
                    lost_hit_s = 1'b1;
                end else begin
                    lost_hit_s = 1'b0;
                end
            end
            ST_REQ, ST_DEAD: lost_hit_s = any_qual_s;
            default:         lost_hit_s = 1'b0;
        endcase
    end

    // Sequencer: gather window, request handshake, dead time and counters
    always_ff @(posedge CLK120 or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            dead_q     <= '0;
            evt_req_q  <= 1'b0;
            evt_type_q <= '0;
            busy_q     <= 1'b0;
            evt_cnt_q  <= '0;
            lost_cnt_q <= '0;
        end else begin
            if (lost_hit_s) begin
                lost_cnt_q <= sat_inc(lost_cnt_q);
            end
            case (state_q)
                ST_IDLE: begin
                    if (any_qual_s && !bus.BUF_FULL) begin
                        evt_type_q <= qual_s;
                        win_q      <= WIN_LOAD;
                        busy_q     <= 1'b1;
                        state_q    <= ST_GATHER;
                    end
                end
                ST_GATHER: begin
                    evt_type_q <= evt_type_q | qual_s;
                    if (win_q == '0) begin
                        evt_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end else begin
                        win_q <= win_q - WIN_ONE;
                    end
                end
                ST_REQ: begin
                    if (bus.EVT_ACK) begin
                        evt_req_q <= 1'b0;
                        evt_cnt_q <= evt_cnt_q + 16'd1;
                        if (bus.DEAD_TIME == '0) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            dead_q  <= bus.DEAD_TIME;
                            state_q <= ST_DEAD;
                        end
                    end
                end
                ST_DEAD: begin
                    if (dead_q <= DEAD_ONE) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        dead_q <= dead_q - DEAD_ONE;
                    end
                end
                default: begin
                    evt_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.EVT_REQ  = evt_req_q;
    assign bus.EVT_TYPE = evt_type_q;
    assign bus.BUSY     = busy_q;
    assign bus.EVT_CNT  = evt_cnt_q;
    assign bus.LOST_CNT = lost_cnt_q;

endmodule

// File: tb/tb_trigger_arbiter.sv
// Self-checking bench for trigger_arbiter: a behavioural model tracks the
// expected outputs and is compared every cycle; directed scenarios add
// hand-computed literal checks.
module tb_trigger_arbiter;
    import trigger_arbiter_pkg::*;

    localparam int NSRC = 6;
    localparam int PSW  = 8;
    localparam int DW   = 16;
    localparam int CW   = 3;

    logic CLK120 = 1'b0;
    logic RST_N;

    always #5 CLK120 = ~CLK120;

    trigger_arbiter_if #(.NSRC(NSRC), .PS_WIDTH(PSW), .DEAD_WIDTH(DW)) bus ();

    trigger_arbiter #(
        .NSRC       (NSRC),
        .PS_WIDTH   (PSW),
        .DEAD_WIDTH (DW),
        .COINC_WIN  (CW)
    ) dut (
        .CLK120 (CLK120),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NSRC-1:0] m_s1, m_q, m_type;
    int  m_pc [NSRC];
    int  m_win;      // remaining gather cycles, -1 when not gathering
    bit  m_wait;     // request outstanding
    int  m_dead;     // remaining dead cycles
    bit  m_req;
    int  m_evt, m_lost;

    function automatic bit m_busy();
        return (m_win >= 0) || m_wait || (m_dead > 0);
    endfunction

    initial begin
        forever begin
            @(posedge CLK120 or negedge RST_N);
            if (!RST_N) begin
                m_s1 = '0; m_q = '0; m_type = '0;
                for (int i = 0; i < NSRC; i++) m_pc[i] = 0;
                m_win = -1; m_wait = 0; m_dead = 0; m_req = 0; m_evt = 0; m_lost = 0;
            end else begin
                bit any, linc;
                logic [NSRC-1:0] masked;
                int n;
                any  = |m_q;
                linc = 0;
                if (m_wait) begin
                    linc = any;
                    if (bus.EVT_ACK) begin
                        m_wait = 0; m_req = 0;
                        m_evt  = (m_evt + 1) % 65536;
                        m_dead = int'(bus.DEAD_TIME);
                    end
                end else if (m_dead > 0) begin
                    linc = any;
                    m_dead--;
                end else if (m_win >= 0) begin
                    m_type |= m_q;
                    if (m_win == 0) begin
                        m_win = -1; m_wait = 1; m_req = 1;
                    end else begin
                        m_win--;
                    end
                end else if (any) begin
                    if (bus.BUF_FULL) begin
                        linc = 1;
                    end else begin
                        m_type = m_q;
                        m_win  = CW - 1;
                    end
                end
                if (linc && m_lost < 65535) m_lost++;
                masked = m_s1 & bus.TRIG_MASK;
                for (int i = 0; i < NSRC; i++) begin
                    m_q[i] = 1'b0;
                    if (masked[i]) begin
                        n = int'(bus.PRESCALE[i*PSW +: PSW]);
                        m_pc[i]++;
                        if (n <= 1 || m_pc[i] >= n) begin
                            m_q[i]  = 1'b1;
                            m_pc[i] = 0;
                        end
                    end
                end
                m_s1 = bus.TRIG_IN;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge CLK120);
            if (cmp_en) begin
                check("cyc_evt_req",  32'(bus.EVT_REQ),  32'(m_req));
                check("cyc_evt_type", 32'(bus.EVT_TYPE), 32'(m_type));
                check("cyc_busy",     32'(bus.BUSY),     32'(m_busy()));
                check("cyc_evt_cnt",  32'(bus.EVT_CNT),  32'(m_evt));
                check("cyc_lost_cnt", 32'(bus.LOST_CNT), 32'(m_lost));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge CLK120);
    endtask

    task automatic pulse(input logic [NSRC-1:0] p);
        bus.TRIG_IN = p;
        tick();
        bus.TRIG_IN = '0;
    endtask

    task automatic do_ack();
        bus.EVT_ACK = 1'b1;
        tick();
        bus.EVT_ACK = 1'b0;
    endtask

    task automatic wait_req(output int c);
        c = 0;
        while (!bus.EVT_REQ && c < 50) begin
            tick();
            c++;
        end
        check("req_wait", 32'(bus.EVT_REQ), 32'd1);
    endtask

    task automatic watch(input int n, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.EVT_REQ) seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        bus.TRIG_IN = '0;
        bus.EVT_ACK = 1'b0;
        bus.BUF_FULL = 1'b0;
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int  c, bc;
        bit  seen;
        int  cnt_after [9];

        RST_N         = 1'b0;
        bus.TRIG_IN   = '0;
        bus.TRIG_MASK = 6'h3F;
        bus.PRESCALE  = '0;
        bus.DEAD_TIME = 16'd10;
        bus.BUF_FULL  = 1'b0;
        bus.EVT_ACK   = 1'b0;
        do_reset();
        cmp_en = 1'b1;

        // Reset state
        check("rst_req",  32'(bus.EVT_REQ),  32'd0);
        check("rst_busy", 32'(bus.BUSY),     32'd0);
        check("rst_type", 32'(bus.EVT_TYPE), 32'd0);

        // 1: single pulse, latency, ACK and dead time
        pulse(6'b000001);
        wait_req(c);
        check("t1_latency", 32'(c), 32'd5);
        check("t1_type", 32'(bus.EVT_TYPE), 32'h01);
        tick();
        do_ack();
        check("t1_req_fall", 32'(bus.EVT_REQ), 32'd0);
        check("t1_evt_cnt", 32'(bus.EVT_CNT), 32'd1);
        bc = 0;
        while (bus.BUSY && bc < 40) begin
            bc++;
            tick();
        end
        check("t1_dead_len", 32'(bc), 32'd10);

        // 2: merge inside window, pulse during REQ is lost
        do_reset();
        pulse(6'b000001);
        tick();
        pulse(6'b000100);
        tick();
        pulse(6'b000010);
        wait_req(c);
        tick();
        do_ack();
        check("t2_type", 32'(bus.EVT_TYPE), 32'h05);
        check("t2_lost", 32'(bus.LOST_CNT), 32'd1);
        check("t2_evt",  32'(bus.EVT_CNT),  32'd1);
        repeat (15) tick();

        // 3: prescale by 4 on source 1
        do_reset();
        bus.PRESCALE  = 48'd4 << 8;
        bus.DEAD_TIME = 16'd5;
        for (int p = 1; p <= 8; p++) begin
            pulse(6'b000010);
            repeat (40) begin
                bus.EVT_ACK = bus.EVT_REQ;
                tick();
            end
            bus.EVT_ACK = 1'b0;
            cnt_after[p] = int'(bus.EVT_CNT);
        end
        check("t3_after3", 32'(cnt_after[3]), 32'd0);
        check("t3_after4", 32'(cnt_after[4]), 32'd1);
        check("t3_after7", 32'(cnt_after[7]), 32'd1);
        check("t3_after8", 32'(cnt_after[8]), 32'd2);
        check("t3_lost", 32'(bus.LOST_CNT), 32'd0);
        bus.PRESCALE = '0;

        // 4: masking and buffer-full blocking
        do_reset();
        bus.DEAD_TIME = 16'd10;
        bus.TRIG_MASK = 6'b111110;
        pulse(6'b000001);
        watch(15, seen);
        check("t4_masked_noreq", 32'(seen), 32'd0);
        check("t4_masked_evt", 32'(bus.EVT_CNT), 32'd0);
        bus.BUF_FULL = 1'b1;
        pulse(6'b001000);
        watch(15, seen);
        check("t4_full_noreq", 32'(seen), 32'd0);
        check("t4_full_lost", 32'(bus.LOST_CNT), 32'd1);
        bus.BUF_FULL = 1'b0;
        pulse(6'b001000);
        wait_req(c);
        check("t4_type", 32'(bus.EVT_TYPE), 32'h08);
        tick();
        do_ack();
        repeat (15) tick();
        bus.TRIG_MASK = 6'h3F;

        // 5: asynchronous reset while requesting
        do_reset();
        bus.DEAD_TIME = 16'd3;
        pulse(6'b000001);
        wait_req(c);
        do_ack();
        repeat (6) tick();
        pulse(6'b000001);
        wait_req(c);
        pulse(6'b000001);
        tick();
        tick();
        check("t5_pre_lost", 32'(bus.LOST_CNT), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("t5_req0",  32'(bus.EVT_REQ),  32'd0);
        check("t5_busy0", 32'(bus.BUSY),     32'd0);
        check("t5_evt0",  32'(bus.EVT_CNT),  32'd0);
        check("t5_lost0", 32'(bus.LOST_CNT), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();
        pulse(6'b010000);
        wait_req(c);
        check("t5_type", 32'(bus.EVT_TYPE), 32'h10);
        do_ack();
        check("t5_evt", 32'(bus.EVT_CNT), 32'd1);
        repeat (6) tick();

        // 6: LOST_CNT saturation while ACK is withheld
        do_reset();
        bus.DEAD_TIME = 16'd0;
        pulse(6'b000001);
        wait_req(c);
        bus.TRIG_IN = 6'b000001;
        repeat (70000) tick();
        check("t6_sat", 32'(bus.LOST_CNT), 32'hFFFF);
        repeat (20) tick();
        check("t6_sat_hold", 32'(bus.LOST_CNT), 32'hFFFF);
        check("t6_req_held", 32'(bus.EVT_REQ), 32'd1);
        bus.TRIG_IN = '0;
        repeat (3) tick();
        do_ack();
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
